chon_mod: RTL

Mode controller for the 12-digit clock display. Debounces the raw "mode" and "increment" push-buttons and runs a 4-state adjust-mode FSM. Produces the 2-bit `gt_mod` code that the decimal-point decoder consumes (00 none, 01 seconds, 10 minutes, 11 hours). Emits one-cycle increment strobes to the seconds, minutes or hours counter of the active mode, and returns to 00 after an idle timeout.

---
 rtl/clock_pkg.sv | 30 +++
 rtl/chong_doi.sv | 53 +++++
 rtl/chon_mod.sv | 89 ++++++++
 3 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clock_pkg
// Brief   : Mode codes and adjust-mode FSM state type for the clock display.
// Revision: 1.0
// ============================================================================
package clock_pkg;

  localparam logic [1:0] MOD_KHONG = 2'b00;
  localparam logic [1:0] MOD_GIAY  = 2'b01;
  localparam logic [1:0] MOD_PHUT  = 2'b10;
  localparam logic [1:0] MOD_GIO   = 2'b11;

  typedef enum logic [1:0] {
    KHONG_CHINH = MOD_KHONG,
    CHINH_GIAY  = MOD_GIAY,
    CHINH_PHUT  = MOD_PHUT,
    CHINH_GIO   = MOD_GIO
  } state_e;

  // Mode button walks 00 -> 01 -> 10 -> 11 -> 00.
  function automatic state_e next_mode(input state_e s);
    logic [1:0] v;
    v = s;
    v = v + 2'd1;
    return state_e'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chong_doi.sv
`default_nettype none
// ============================================================================
// Module  : chong_doi
// Brief   : Button synchronizer, debounce counter and press (rising) detector.
// Revision: 1.0
// ============================================================================
module chong_doi #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] c_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      // Any cycle agreeing with the accepted level throws away a partial count.
      if (r_sync2 != r_deb) begin
        if (r_cnt == c_LAST) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press = r_deb & ~r_deb_d;

endmodule
`default_nettype wire

// File: rtl/chon_mod.sv
`default_nettype none
// ============================================================================
// Module  : chon_mod
// Brief   : Adjust-mode controller: debounced buttons, mode FSM, increment
//           strobes and idle timeout back to normal display.
// Revision: 1.0
// ============================================================================
module chon_mod
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mod,
  input  logic       btn_tang,
  output logic [1:0] gt_mod,
  output logic       tang_giay,
  output logic       tang_phut,
  output logic       tang_gio
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] c_TO_LAST = IW'(TIMEOUT_CYCLES - 1);

  logic          w_press_mod;
  logic          w_press_tang;
  state_e        r_state;
  logic [IW-1:0] r_idle;
  logic          r_giay;
  logic          r_phut;
  logic          r_gio;

  chong_doi #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mod (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mod),
    .press (w_press_mod)
  );

  chong_doi #(.DEB_CYCLES(DEB_CYCLES)) u_deb_tang (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_tang),
    .press (w_press_tang)
  );

  // Priority: mode press, then increment press, then idle/timeout handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= KHONG_CHINH;
      r_idle  <= '0;
      r_giay  <= 1'b0;
      r_phut  <= 1'b0;
      r_gio   <= 1'b0;
    end else begin
      r_giay <= 1'b0;
      r_phut <= 1'b0;
      r_gio  <= 1'b0;
      if (w_press_mod) begin
        r_state <= next_mode(r_state);
        r_idle  <= '0;
      end else if (w_press_tang) begin
        r_idle <= '0;
        case (r_state)
          CHINH_GIAY: r_giay <= 1'b1;
          CHINH_PHUT: r_phut <= 1'b1;
          CHINH_GIO:  r_gio  <= 1'b1;
          default:    ;
        endcase
      end else if (r_state == KHONG_CHINH) begin
        r_idle <= '0;
      end else if (r_idle >= c_TO_LAST) begin
        r_state <= KHONG_CHINH;
        r_idle  <= '0;
      end else begin
        r_idle <= r_idle + 1'b1;
      end
    end
  end

  assign gt_mod    = r_state;
  assign tang_giay = r_giay;
  assign tang_phut = r_phut;
  assign tang_gio  = r_gio;

endmodule
`default_nettype wire
